// File: rtl/shift_out_16bit.sv
// shift_out_16bit: parallel-to-serial transmitter.
// A word is loaded over a valid/ready handshake into a shift register and
// sent one bit per accepted beat on a serial valid/ready channel.
// A one-cycle done pulse follows the last accepted bit.
module shift_out_16bit #(
  parameter int WIDTH     = 16,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             tx_last,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic [CW-1:0]    r_count;
  logic             r_done;
  logic             w_load;
  logic             w_beat;
  logic             w_last;

  // load_ready is exactly "state is IDLE", so the handshake reduces to this
  assign w_load = load_valid && (r_state == S_IDLE);
  assign w_beat = (r_state == S_SHIFT) && tx_ready;
  assign w_last = (r_count == LAST);

  // Shift toward the output end with zero fill
  generate
    if (LSB_FIRST) begin : g_lsb
      assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
    end else begin : g_msb
      assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state: leave IDLE on a load, leave SHIFT on the final beat
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_load)           w_next = S_SHIFT;
      S_SHIFT: if (w_beat && w_last) w_next = S_IDLE;
      default:                       w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; serial outputs are forced low while IDLE
  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b0;
    tx_valid   = 1'b0;
    tx_bit     = 1'b0;
    tx_last    = 1'b0;
    done       = r_done;
    case (r_state)
      S_IDLE: load_ready = 1'b1;
      S_SHIFT: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_bit   = LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1];
        tx_last  = w_last;
      end
      default: ;
    endcase
  end

  // Transfer gate: select new data on load, shifted data on a beat, else hold
  always_comb begin
    w_shreg_nxt = r_shreg;
    if (w_load)      w_shreg_nxt = load_data;
    else if (w_beat) w_shreg_nxt = w_shifted;
  end

  // Datapath: shift register, bit counter and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_shreg <= w_shreg_nxt;
      r_done  <= w_beat && w_last;
      // count saturates at LAST; the next load clears it
      if (w_load)                 r_count <= '0;
      else if (w_beat && !w_last) r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_out_16bit.sv
// tb_shift_out_16bit: drives an MSB-first and an LSB-first instance with the
// same stimulus and checks both against a word/index reference model.
module tb_shift_out_16bit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         tx_ready;
  logic [1:0]   load_ready, tx_bit, tx_valid, tx_last, busy, done;

  always #5 clk = ~clk;

  shift_out_16bit #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready[0]),
    .load_data(load_data), .tx_bit(tx_bit[0]), .tx_valid(tx_valid[0]),
    .tx_last(tx_last[0]), .tx_ready(tx_ready), .busy(busy[0]), .done(done[0])
  );

  shift_out_16bit #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready[1]),
    .load_data(load_data), .tx_bit(tx_bit[1]), .tx_valid(tx_valid[1]),
    .tx_last(tx_last[1]), .tx_ready(tx_ready), .busy(busy[1]), .done(done[1])
  );

  // Reference model: the word in flight plus how many bits were accepted
  bit           m_busy;
  logic [W-1:0] m_word;
  int           m_idx;
  bit           m_done;
  bit           acc;

  int           nvec, nerr, cyc;
  logic [W-1:0] rx [2];
  int           ndone [2];
  int           nvalid [2];
  bit           pv;
  int           fbq [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: record accepted bits, advance the model, compare all outputs
  task automatic tick();
    logic [5:0] got6, exp6;
    logic       e;
    for (int k = 0; k < 2; k++)
      if (!rst && tx_valid[k] === 1'b1 && tx_ready) begin
        rx[k] = (k == 0) ? {rx[k][W-2:0], tx_bit[k]} : {tx_bit[k], rx[k][W-1:1]};
        nvalid[k]++;
      end
    @(posedge clk);
    cyc++;
    acc = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_idx = 0; m_done = 1'b0; m_word = '0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (load_valid) begin
          m_busy = 1'b1; m_word = load_data; m_idx = 0; acc = 1'b1;
        end
      end else if (tx_ready) begin
        m_idx++;
        if (m_idx == W) begin
          m_busy = 1'b0; m_done = 1'b1;
        end
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      e    = m_busy ? ((k == 0) ? m_word[W-1-m_idx] : m_word[m_idx]) : 1'b0;
      exp6 = {!m_busy, m_busy, m_busy, e, m_busy && (m_idx == W-1), m_done};
      got6 = {load_ready[k], busy[k], tx_valid[k], tx_bit[k], tx_last[k], done[k]};
      chk($sformatf("outs%0d_cyc%0d", k, cyc), 32'(got6), 32'(exp6));
      if (done[k] === 1'b1) ndone[k]++;
    end
    if (tx_valid[0] === 1'b1 && !pv) fbq.push_back(cyc);
    pv = (tx_valid[0] === 1'b1);
  endtask

  task automatic clr();
    ndone  = '{0, 0};
    nvalid = '{0, 0};
    fbq.delete();
  endtask

  int i, nloads, snap;

  initial begin
    nvec = 0; nerr = 0; cyc = 0; pv = 1'b0;
    m_busy = 0; m_idx = 0; m_done = 0; m_word = '0;
    rx = '{16'h0, 16'h0};
    clr();
    rst = 1'b1; load_valid = 1'b0; load_data = '0; tx_ready = 1'b0;

    // Reset, then idle with tx_ready toggling
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tx_ready = (k % 2 == 1);
      tick();
    end

    // Basic word, tx_ready held high
    clr();
    load_data = 16'hA5C3; load_valid = 1'b1; tx_ready = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (17) tick();
    chk("a5c3_msb_word", 32'(rx[0]), 32'h0000A5C3);
    chk("a5c3_lsb_word", 32'(rx[1]), 32'h0000A5C3);
    chk("a5c3_nvalid",   32'(nvalid[0]), 32'd16);
    chk("a5c3_ndone",    32'(ndone[0]), 32'd1);

    // Backpressure: tx_ready 1,0,0,1,0,0,...
    clr();
    load_data = 16'h8001; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    i = 0;
    while (ndone[0] == 0 && i < 100) begin
      tx_ready = (i % 3 == 0);
      tick();
      i++;
    end
    chk("bp_timeout", 32'(i < 100), 32'd1);
    chk("bp_msb_word", 32'(rx[0]), 32'h00008001);
    chk("bp_lsb_word", 32'(rx[1]), 32'h00008001);
    chk("bp_nvalid",   32'(nvalid[1]), 32'd16);

    // Busy rejection: a second word offered during SHIFT waits for IDLE
    clr();
    tx_ready = 1'b1;
    load_data = 16'hFFFF; load_valid = 1'b1;
    tick();
    load_data = 16'h0000;
    i = 0;
    while (ndone[0] == 0 && i < 100) begin
      tick();
      i++;
    end
    chk("busy_timeout", 32'(i < 100), 32'd1);
    chk("busy_first_word", 32'(rx[0]), 32'h0000FFFF);
    tick();
    load_valid = 1'b0;
    repeat (17) tick();
    chk("busy_second_word", 32'(rx[0]), 32'h00000000);
    chk("busy_ndone", 32'(ndone[0]), 32'd2);

    // Back-to-back: second word accepted in the done cycle
    clr();
    load_data = 16'h1234; load_valid = 1'b1; nloads = 0;
    repeat (40) begin
      tick();
      if (acc) begin
        nloads++;
        if (nloads == 1) load_data = 16'hFFFF;
        else             load_valid = 1'b0;
      end
    end
    chk("b2b_nstarts", 32'(fbq.size()), 32'd2);
    chk("b2b_gap", (fbq.size() >= 2) ? 32'(fbq[1] - fbq[0]) : 32'hFFFFFFFF, 32'd17);
    chk("b2b_last_word", 32'(rx[0]), 32'h0000FFFF);
    chk("b2b_ndone", 32'(ndone[0]), 32'd2);

    // Reset mid-word: partial word dropped, no done pulse
    clr();
    load_data = 16'hF0F0; load_valid = 1'b1; tx_ready = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_tx_valid", 32'(tx_valid[0]), 32'd0);
    chk("rst_load_ready", 32'(load_ready[1]), 32'd1);
    repeat (3) tick();
    chk("rst_no_done", 32'(ndone[0] + ndone[1]), 32'd0);
    load_data = 16'h0001; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk("rst_lsb_first_bit", 32'(tx_bit[1]), 32'd1);
    chk("rst_msb_first_bit", 32'(tx_bit[0]), 32'd0);
    snap = ndone[0];
    repeat (17) tick();
    chk("rst_msb_word", 32'(rx[0]), 32'h00000001);
    chk("rst_lsb_word", 32'(rx[1]), 32'h00000001);
    chk("rst_ndone", 32'(ndone[0] - snap), 32'd1);

    // Random traffic including occasional resets
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 199) == 0);
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = 16'($urandom);
      tx_ready   = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst = 1'b0; load_valid = 1'b0; tx_ready = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
